// File: rtl/display_scan_driver_if.sv
// Digit write bus and scan outputs of the display scan driver.
// master drives writes and blink_en; slave drives the display pins.
interface display_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [4:0]      wr_char;
  logic            wr_blink;
  logic            blink_en;
  logic [6:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic            frame_tick;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_char,
    output wr_blink,
    output blink_en,
    input  seg_n,
    input  an_n,
    input  frame_tick
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_char,
    input  wr_blink,
    input  blink_en,
    output seg_n,
    output an_n,
    output frame_tick
  );
endinterface

// File: rtl/display_scan_driver.sv
// Multiplexed 7-segment scan driver with per-digit blink.
// One blank slot-cycle per digit suppresses ghosting.
module display_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
  display_scan_driver_if.slave bus
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST =
    SW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST =
    AW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST =
    FW'(BLINK_FRAMES - 1);
  localparam logic [AW:0] ND_W =
    (AW + 1)'(NUM_DIGITS);

  logic [SW-1:0] slot_q, slot_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;

  logic [4:0]            chars_q [NUM_DIGITS];
  logic [4:0]            chars_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blink_q, blink_d;

  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic slot_wrap;
  logic tick;
  logic wr_ok;
  logic blank;

  function automatic logic [6:0] glyph(
    input logic [4:0] c
  );
    case (c)
      5'd0:    glyph = 7'b1000000;
      5'd1:    glyph = 7'b1111001;
      5'd2:    glyph = 7'b0100100;
      5'd3:    glyph = 7'b0110000;
      5'd4:    glyph = 7'b0011001;
      5'd5:    glyph = 7'b0010010;
      5'd6:    glyph = 7'b0000010;
      5'd7:    glyph = 7'b1111000;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0010000;
      5'd10:   glyph = 7'b0001000;
      5'd11:   glyph = 7'b1000110;
      5'd12:   glyph = 7'b0000110;
      5'd13:   glyph = 7'b0001110;
      5'd14:   glyph = 7'b1000111;
      5'd15:   glyph = 7'b1000001;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Slot, digit, frame and blink-phase counters.
  // tick marks the terminal cycle of the last slot.
  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    tick      = slot_wrap && (idx_q == IDX_LAST);
    slot_d    = slot_wrap ? '0 : slot_q + SW'(1);
    idx_d     = idx_q;
    frame_d   = frame_q;
    phase_d   = phase_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ?
        '0 : idx_q + AW'(1);
    end
    if (tick) begin
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // Digit register file; out-of-range writes drop.
  always_comb begin
    wr_ok   = bus.wr_en && ({1'b0, bus.wr_addr} < ND_W);
    chars_d = chars_q;
    blink_d = blink_q;
    if (wr_ok) begin
      chars_d[bus.wr_addr] = bus.wr_char;
      blink_d[bus.wr_addr] = bus.wr_blink;
    end
  end

  // Next display pins from pre-edge state.
  // Slot 0 is the dark anti-ghosting gap.
  always_comb begin
    blank = (slot_q == '0) ||
      (bus.blink_en && phase_q && blink_q[idx_q]);
    an_d  = '1;
    if (slot_q != '0) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = blank ? 7'b1111111 : glyph(chars_q[idx_q]);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      blink_q <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        chars_q[i] <= 5'd31;
      end
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      chars_q <= chars_d;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.an_n       = an_q;
  assign bus.frame_tick = tick;

endmodule
